tri_wave_checker: RTL

Monitor on the receiving end of the 4-bit bouncing up/down counter stream. It consumes one sample per valid cycle and acquires lock on the triangle sequence 0,1,…,15,15,14,…,0,0,1,… in which each extreme is emitted twice. Once locked, it reports direction, peak and trough events, completed periods and sequence errors. It sits beside the counter in test and self-check builds and drives status LEDs or a scoreboard.

---
 rtl/tri_check_pkg.sv | 9 +
 rtl/sat_counter8.sv | 11 +
 rtl/tri_wave_checker.sv | 90 +++++++++
 3 files changed

// File: rtl/tri_check_pkg.sv
// tri_check_pkg: shared state encoding, default widths and sample maximum helper
package tri_check_pkg;
  typedef enum logic [2:0] {IDLE, PRIME, UP, TOP, DOWN, BOT} tri_state_e;
  localparam int TRI_WIDTH = 4;
  localparam int TRI_PCNT_W = 8;
  function automatic int max_val(input int width);
    return (1 << width) - 1;
  endfunction
endpackage

// File: rtl/sat_counter8.sv
// sat_counter8: 8-bit counter with increment enable and sync clear, saturating at 255
module sat_counter8 (
  input  logic       clock,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] count
);
  // count up on inc, stick at 255, clear wins
  always_ff @(posedge clock)
    count <= clear ? 8'd0 : (inc && count != 8'hff) ? count + 8'd1 : count;
endmodule

// File: rtl/tri_wave_checker.sv
// tri_wave_checker: lock onto a bouncing up/down counter stream; optional error counter via TRI_CHECK_ERRCNT_EN
module tri_wave_checker
  import tri_check_pkg::*;
#(
  parameter int WIDTH  = TRI_WIDTH,
  parameter int PCNT_W = TRI_PCNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [WIDTH-1:0]  sample,
  output logic              locked,
  output logic              dir,
  output logic [WIDTH-1:0]  expected,
  output logic              peak,
  output logic              trough,
  output logic              err,
  output logic [PCNT_W-1:0] period_count,
  output logic [7:0]        err_count
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_val(WIDTH));
  tri_state_e state, nstate;
  logic [WIDTH-1:0] last, nexp;
  logic [WIDTH:0] s, up_v, dn_v, exp_v;
  logic hit, same, is_max, is_zero, in_lock, pk, tr, er, ndir;
  // next state, pulses and next expected value for the sample on the bus
  always_comb begin
    s = {1'b0, sample};
    up_v = {1'b0, last} + (WIDTH+1)'(1);
    dn_v = {1'b0, last} - (WIDTH+1)'(1);
    is_max = sample == MAX;
    is_zero = sample == '0;
    same = sample == last;
    in_lock = state inside {UP, TOP, DOWN, BOT};
    exp_v = state == UP ? up_v : state == DOWN ? dn_v : state == TOP ? {1'b0, MAX} : '0;
    hit = s == exp_v;
    case (state)
      IDLE:    nstate = PRIME;
      PRIME:   nstate = s == up_v ? (is_max ? TOP : UP) : s == dn_v ? (is_zero ? BOT : DOWN) :
                        (same && is_max) ? DOWN : (same && is_zero) ? UP : PRIME;
      UP:      nstate = !hit ? PRIME : is_max ? TOP : UP;
      TOP:     nstate = hit ? DOWN : PRIME;
      DOWN:    nstate = !hit ? PRIME : is_zero ? BOT : DOWN;
      BOT:     nstate = hit ? UP : PRIME;
      default: nstate = IDLE;
    endcase
    pk = state == PRIME ? same && is_max : state == TOP && hit;
    tr = state == PRIME ? same && is_zero : state == BOT && hit;
    er = in_lock && !hit;
    nexp = nstate == UP ? sample + WIDTH'(1) : nstate == DOWN ? sample - WIDTH'(1) :
           nstate == TOP ? MAX : '0;
    ndir = nstate inside {TOP, DOWN} ? 1'b1 : nstate inside {UP, BOT} ? 1'b0 : dir;
  end
  // consume one sample per valid cycle; pulses only on the consuming cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      last <= '0;
      locked <= 1'b0;
      dir <= 1'b0;
      expected <= '0;
      peak <= 1'b0;
      trough <= 1'b0;
      err <= 1'b0;
      period_count <= '0;
    end else begin
      peak <= valid && pk;
      trough <= valid && tr;
      err <= valid && er;
      if (valid) begin
        state <= nstate;
        last <= sample;
        locked <= nstate inside {UP, TOP, DOWN, BOT};
        dir <= ndir;
        expected <= nexp;
        period_count <= period_count + PCNT_W'(tr);
      end
    end
  end
`ifdef TRI_CHECK_ERRCNT_EN
  sat_counter8 u_errcnt (
    .clock(clock),
    .clear(reset),
    .inc  (valid && er),
    .count(err_count)
  );
`else
  assign err_count = 8'd0;
`endif
endmodule
